// File: rtl/output_port_arbiter.sv
// Round-robin arbiter sharing one router output unit among NUM_INPUTS input
// units. A winner is picked in IDLE, requests the output unit in REQUEST, and
// holds a packet-level lock in LOCKED until its tail flit crosses.
module output_port_arbiter #(
   parameter int NUM_INPUTS = 5,
   parameter int IDX_W      = $clog2(NUM_INPUTS),
   parameter int MAX_HOLD   = 255
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_INPUTS-1:0] i_req,
   input  logic                  i_flit_valid,
   input  logic                  i_flit_tail,
   input  logic                  i_switch_ack,
   output logic                  o_switch_req,
   output logic [NUM_INPUTS-1:0] o_grant,
   output logic [IDX_W-1:0]      o_sel,
   output logic                  o_busy,
   output logic                  o_timeout
);

   localparam int HC_W = $clog2(MAX_HOLD + 1);

   typedef enum logic [1:0] {IDLE, REQUEST, LOCKED} state_t;

   state_t                state;
   logic [IDX_W-1:0]      rr_ptr;
   logic [IDX_W-1:0]      win_idx;
   logic [IDX_W-1:0]      win_pick;
   logic [HC_W-1:0]       hold_cnt;
   logic [IDX_W-1:0]      cand_idx [NUM_INPUTS];
   logic [NUM_INPUTS-1:0] win_onehot;
   logic                  tail_seen;

   assign tail_seen = i_flit_valid & i_flit_tail;
   assign o_sel     = win_idx;

   // cand_idx[gi] is the input examined gi places after rr_ptr, wrapped
   // modulo NUM_INPUTS (which need not be a power of two).
   for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum = {1'b0, rr_ptr} + (IDX_W+1)'(gi);
      assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_INPUTS))
                            ? IDX_W'(sum - (IDX_W+1)'(NUM_INPUTS))
                            : sum[IDX_W-1:0];
      assign win_onehot[gi] = (win_idx == IDX_W'(gi));
   end

   // First requesting input at or after rr_ptr; lowest offset wins.
   always_comb begin
      win_pick = rr_ptr;
      for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
         if (i_req[cand_idx[k]]) win_pick = cand_idx[k];
      end
   end

   // Arbitration FSM with registered outputs; the lock is packet-granular.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         win_idx      <= '0;
         hold_cnt     <= '0;
         o_switch_req <= 1'b0;
         o_grant      <= '0;
         o_busy       <= 1'b0;
         o_timeout    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|i_req) begin
                  win_idx      <= win_pick;
                  state        <= REQUEST;
                  o_switch_req <= 1'b1;
                  o_busy       <= 1'b1;
               end
            end
            REQUEST: begin
               if (!i_req[win_idx]) begin
                  // Requester withdrew: abort without moving the pointer.
                  state        <= IDLE;
                  o_switch_req <= 1'b0;
                  o_busy       <= 1'b0;
               end else if (i_switch_ack) begin
                  state        <= LOCKED;
                  hold_cnt     <= '0;
                  o_switch_req <= 1'b0;
                  o_grant      <= win_onehot;
               end
            end
            LOCKED: begin
               if (hold_cnt != HC_W'(MAX_HOLD)) hold_cnt <= hold_cnt + 1'b1;
               if (tail_seen) begin
                  rr_ptr  <= (win_idx == IDX_W'(NUM_INPUTS - 1)) ? '0 : win_idx + 1'b1;
                  state   <= IDLE;
                  o_grant <= '0;
                  o_busy  <= 1'b0;
               end else if (hold_cnt >= HC_W'(MAX_HOLD - 1)) begin
                  // Counter reaches MAX_HOLD at this edge; the lock is kept.
                  o_timeout <= 1'b1;
               end
            end
            default: begin
               state        <= IDLE;
               o_switch_req <= 1'b0;
               o_grant      <= '0;
               o_busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule
